// File: rtl/clock_tick_timekeeper.sv
// clock_tick_timekeeper
// Receives the 100 Hz divided clock in the clk_in domain, turns each rising
// edge into a one-cycle tick, and keeps a BCD time of day (hh:mm:ss.cc) with
// run / clear / set controls. A watchdog flags a divided clock that has gone
// quiet for TIMEOUT_CYCLES clk_in cycles.
//
// Control strobes: clear and set_en are sampled on every clk_in edge and act
// on that edge only; there is no backpressure. Per edge the winner is
// rst > clear > set_en > (tick & run). A rejected set leaves the time alone
// and does not consume the tick, so time can still advance in that cycle.
module clock_tick_timekeeper #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       div_clk,
  input  logic       run,
  input  logic       clear,
  input  logic       set_en,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  output logic       tick,
  output logic [7:0] cc,
  output logic [7:0] ss,
  output logic [7:0] mm,
  output logic [7:0] hh,
  output logic       sec_pulse,
  output logic       day_wrap,
  output logic       set_err,
  output logic       stalled
);

  // Fewer than two flops is not a synchronizer; clamp silently.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------

  // Two-digit BCD increment without wrap; callers handle the wrap points.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Both nibbles are decimal digits and the tens digit is within tens_max.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [3:0] tens_max);
    return (v[3:0] <= 4'd9) && (v[7:4] <= tens_max);
  endfunction

  // ---------------------------------------------------------------------
  // Synchronizer and rising-edge detector
  // ---------------------------------------------------------------------
  logic [SYNC_N-1:0] sync_q;
  logic              prev_q;
  logic              sync_out;

  assign sync_out = sync_q[SYNC_N-1];

  // Shift div_clk through the synchronizer and register a tick on each rising edge.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], div_clk};
      prev_q <= sync_out;
      tick   <= sync_out & ~prev_q;
    end
  end

  // ---------------------------------------------------------------------
  // Time-of-day next state
  // ---------------------------------------------------------------------
  logic       set_valid;
  logic       advance;
  logic       cc_wrap;
  logic       ss_wrap;
  logic       mm_wrap;
  logic       hh_wrap;
  logic [7:0] cc_inc;
  logic [7:0] ss_inc;
  logic [7:0] mm_inc;
  logic [7:0] hh_inc;
  logic [7:0] cc_n;
  logic [7:0] ss_n;
  logic [7:0] mm_n;
  logic [7:0] hh_n;
  logic       sec_n;
  logic       day_n;
  logic       err_n;

  // Decide whether a set request is loadable: decimal digits, 00-23 / 00-59 / 00-59.
  always_comb begin
    set_valid = bcd_ok(set_hh, 4'd2) && (set_hh <= 8'h23) &&
                bcd_ok(set_mm, 4'd5) &&
                bcd_ok(set_ss, 4'd5);
  end

  // Precompute the incremented digits and the wrap point of each field.
  always_comb begin
    cc_wrap = (cc == 8'h99);
    ss_wrap = (ss == 8'h59);
    mm_wrap = (mm == 8'h59);
    hh_wrap = (hh == 8'h23);
    cc_inc  = cc_wrap ? 8'h00 : bcd_inc(cc);
    ss_inc  = ss_wrap ? 8'h00 : bcd_inc(ss);
    mm_inc  = mm_wrap ? 8'h00 : bcd_inc(mm);
    hh_inc  = hh_wrap ? 8'h00 : bcd_inc(hh);
  end

  // Apply clear / set / tick priority and ripple the carry through the fields.
  always_comb begin
    cc_n    = cc;
    ss_n    = ss;
    mm_n    = mm;
    hh_n    = hh;
    sec_n   = 1'b0;
    day_n   = 1'b0;
    err_n   = 1'b0;
    advance = 1'b0;

    if (clear) begin
      cc_n = 8'h00;
      ss_n = 8'h00;
      mm_n = 8'h00;
      hh_n = 8'h00;
    end else if (set_en) begin
      if (set_valid) begin
        cc_n = 8'h00;
        ss_n = set_ss;
        mm_n = set_mm;
        hh_n = set_hh;
      end else begin
        // Rejected set: flag it, but a tick in this cycle still counts.
        err_n   = 1'b1;
        advance = tick & run;
      end
    end else begin
      advance = tick & run;
    end

    if (advance) begin
      cc_n = cc_inc;
      if (cc_wrap) begin
        sec_n = 1'b1;
        ss_n  = ss_inc;
        if (ss_wrap) begin
          mm_n = mm_inc;
          if (mm_wrap) begin
            hh_n = hh_inc;
            if (hh_wrap) begin
              day_n = 1'b1;
            end
          end
        end
      end
    end
  end

  // Register the time fields together with their event pulses.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cc        <= 8'h00;
      ss        <= 8'h00;
      mm        <= 8'h00;
      hh        <= 8'h00;
      sec_pulse <= 1'b0;
      day_wrap  <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      cc        <= cc_n;
      ss        <= ss_n;
      mm        <= mm_n;
      hh        <= hh_n;
      sec_pulse <= sec_n;
      day_wrap  <= day_n;
      set_err   <= err_n;
    end
  end

  // ---------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------
  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_n;

  // Restart on every tick (run does not matter), otherwise count up and saturate.
  always_comb begin
    if (tick) begin
      wd_n = '0;
    end else if (wd_cnt == WD_MAX) begin
      wd_n = wd_cnt;
    end else begin
      wd_n = wd_cnt + WD_W'(1);
    end
  end

  // Hold the counter and a registered copy of its "saturated" condition.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      stalled <= 1'b0;
    end else begin
      wd_cnt  <= wd_n;
      stalled <= (wd_n == WD_MAX);
    end
  end

endmodule

// File: tb/tb_clock_tick_timekeeper.sv
// tb_clock_tick_timekeeper
// Drives div_clk and the time controls, keeps a reference model of the time
// of day as a plain count of hundredths since midnight, and compares the DUT
// against it every cycle as well as in per-scenario checks.
module tb_clock_tick_timekeeper;

  localparam int SYNC_STAGES = 2;
  localparam int TO          = 20000;
  localparam int DAY         = 8640000;
  localparam int LAT         = SYNC_STAGES + 1;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic       div_clk = 1'b0;
  logic       run    = 1'b0;
  logic       clear  = 1'b0;
  logic       set_en = 1'b0;
  logic [7:0] set_hh = 8'h00;
  logic [7:0] set_mm = 8'h00;
  logic [7:0] set_ss = 8'h00;
  logic       tick;
  logic [7:0] cc, ss, mm, hh;
  logic       sec_pulse, day_wrap, set_err, stalled;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  clock_tick_timekeeper #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .div_clk  (div_clk),
    .run      (run),
    .clear    (clear),
    .set_en   (set_en),
    .set_hh   (set_hh),
    .set_mm   (set_mm),
    .set_ss   (set_ss),
    .tick     (tick),
    .cc       (cc),
    .ss       (ss),
    .mm       (mm),
    .hh       (hh),
    .sec_pulse(sec_pulse),
    .day_wrap (day_wrap),
    .set_err  (set_err),
    .stalled  (stalled)
  );

  // ---------------- reference model ----------------
  int   tick_q[$];      // cycles in which a tick is expected to be visible
  int   m_time    = 0;  // hundredths since midnight
  logic m_sec     = 1'b0;
  logic m_day     = 1'b0;
  logic m_err     = 1'b0;
  int   m_err_cnt = 0;
  int   zero_cyc  = 0;  // first cycle in which the watchdog count is zero

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // A byte is a legal field value when it round-trips through decimal and is in range.
  function automatic bit field_ok(input logic [7:0] v, input int lim);
    int n;
    n = bcd2int(v);
    return (n <= lim) && (int2bcd(n) == v);
  endfunction

  function automatic bit set_ok(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    return field_ok(h, 23) && field_ok(m, 59) && field_ok(s, 59);
  endfunction

  function automatic logic [31:0] model_time();
    return {int2bcd(m_time / 360000), int2bcd((m_time / 6000) % 60),
            int2bcd((m_time / 100) % 60), int2bcd(m_time % 100)};
  endfunction

  // Advance the model on every clk_in edge using the inputs the DUT sees.
  always @(posedge clk_in or posedge rst) begin
    int k;
    bit t;
    if (rst) begin
      m_time = 0;
      m_sec  = 1'b0;
      m_day  = 1'b0;
      m_err  = 1'b0;
      tick_q.delete();
      zero_cyc = cyc + 1;
    end else begin
      k = cyc;
      t = 1'b0;
      while (tick_q.size() > 0 && tick_q[0] < k) void'(tick_q.pop_front());
      if (tick_q.size() > 0 && tick_q[0] == k) begin
        t = 1'b1;
        void'(tick_q.pop_front());
        zero_cyc = k + 1;
      end
      m_sec = 1'b0;
      m_day = 1'b0;
      m_err = 1'b0;
      if (clear) begin
        m_time = 0;
      end else if (set_en && set_ok(set_hh, set_mm, set_ss)) begin
        m_time = (bcd2int(set_hh) * 3600 + bcd2int(set_mm) * 60 + bcd2int(set_ss)) * 100;
      end else begin
        if (set_en) begin
          m_err = 1'b1;
          m_err_cnt++;
        end
        if (t && run) begin
          m_time = (m_time + 1) % DAY;
          m_sec  = (m_time % 100 == 0);
          m_day  = (m_time == 0);
        end
      end
    end
  end

  // ---------------- per-cycle monitor ----------------
  int mon_bad       = 0;
  int tick_seen     = 0;
  int sec_seen      = 0;
  int day_seen      = 0;
  int err_seen      = 0;
  int last_tick_cyc = 0;

  // Compare every output with the model away from the active edge.
  always @(negedge clk_in) begin
    logic exp_tick;
    logic exp_stall;
    if (!rst) begin
      exp_tick  = (tick_q.size() > 0 && tick_q[0] == cyc);
      exp_stall = ((cyc - zero_cyc) >= TO);
      if (tick !== exp_tick || {hh, mm, ss, cc} !== model_time() ||
          sec_pulse !== m_sec || day_wrap !== m_day || set_err !== m_err ||
          stalled !== exp_stall) begin
        mon_bad++;
        if (mon_bad <= 8)
          $display("monitor: cycle %0d got tick=%b %h sp=%b dw=%b err=%b st=%b, want tick=%b %h sp=%b dw=%b err=%b st=%b",
                   cyc, tick, {hh, mm, ss, cc}, sec_pulse, day_wrap, set_err, stalled,
                   exp_tick, model_time(), m_sec, m_day, m_err, exp_stall);
      end
      if (tick === 1'b1) begin
        tick_seen++;
        last_tick_cyc = cyc;
      end
      if (sec_pulse === 1'b1) sec_seen++;
      if (day_wrap === 1'b1) day_seen++;
      if (set_err === 1'b1) err_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic rise();
    if (!div_clk) tick_q.push_back(cyc + LAT);
    div_clk = 1'b1;
  endtask

  task automatic fall();
    div_clk = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      rise();
      wait_neg(10);
      fall();
      wait_neg(10);
    end
  endtask

  task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_hh = h;
    set_mm = m;
    set_ss = s;
    set_en = 1'b1;
    wait_neg(1);
    set_en = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    wait_neg(3);
    total_cnt++; if (tick !== 1'b0) $display("FAIL reset_tick got %b want 0", tick); else pass_cnt++;
    total_cnt++; if ({hh, mm, ss, cc} !== 32'h0) $display("FAIL reset_time got %h want 00000000", {hh, mm, ss, cc}); else pass_cnt++;
    total_cnt++; if ({sec_pulse, day_wrap, set_err, stalled} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {sec_pulse, day_wrap, set_err, stalled}); else pass_cnt++;
    rst = 1'b0;
    wait_neg(5);
  endtask

  task automatic test_count();
    int t0, s0, c0;
    run = 1'b1;
    t0 = tick_seen;
    s0 = sec_seen;
    c0 = cyc;
    rise();
    wait_neg(LAT - 1);
    total_cnt++; if (tick !== 1'b0) $display("FAIL count_early_tick got %b want 0 at +%0d", tick, cyc - c0); else pass_cnt++;
    wait_neg(1);
    total_cnt++; if (tick !== 1'b1) $display("FAIL count_latency got %b want 1 at +%0d", tick, cyc - c0); else pass_cnt++;
    wait_neg(10 - LAT);
    fall();
    wait_neg(10);
    pulses(149);
    total_cnt++; if (tick_seen - t0 !== 150) $display("FAIL count_ticks got %0d want 150", tick_seen - t0); else pass_cnt++;
    total_cnt++; if ({hh, mm, ss, cc} !== 32'h00000150) $display("FAIL count_time got %h want 00000150", {hh, mm, ss, cc}); else pass_cnt++;
    total_cnt++; if (sec_seen - s0 !== 1) $display("FAIL count_sec_pulses got %0d want 1", sec_seen - s0); else pass_cnt++;
  endtask

  task automatic test_day_wrap();
    int d0, s0;
    do_set(8'h23, 8'h59, 8'h59);
    total_cnt++; if ({hh, mm, ss, cc} !== 32'h23595900) $display("FAIL wrap_set got %h want 23595900", {hh, mm, ss, cc}); else pass_cnt++;
    d0 = day_seen;
    s0 = sec_seen;
    pulses(99);
    total_cnt++; if ({hh, mm, ss, cc} !== 32'h23595999 || day_seen != d0) $display("FAIL wrap_pre got %h days %0d want 23595999 days 0", {hh, mm, ss, cc}, day_seen - d0); else pass_cnt++;
    rise();
    wait_neg(LAT + 1);
    total_cnt++; if ({hh, mm, ss, cc} !== 32'h0) $display("FAIL wrap_time got %h want 00000000", {hh, mm, ss, cc}); else pass_cnt++;
    total_cnt++; if ({day_wrap, sec_pulse} !== 2'b11) $display("FAIL wrap_pulses got dw=%b sp=%b want 1 1", day_wrap, sec_pulse); else pass_cnt++;
    wait_neg(1);
    total_cnt++; if ({day_wrap, sec_pulse} !== 2'b00) $display("FAIL wrap_pulse_width got dw=%b sp=%b want 0 0", day_wrap, sec_pulse); else pass_cnt++;
    wait_neg(10 - LAT - 2);
    fall();
    wait_neg(10);
    total_cnt++; if (day_seen - d0 !== 1 || sec_seen - s0 !== 1) $display("FAIL wrap_counts got days %0d secs %0d want 1 1", day_seen - d0, sec_seen - s0); else pass_cnt++;
  endtask

  task automatic test_set_err();
    do_set(8'h12, 8'h60, 8'h00);
    total_cnt++; if (set_err !== 1'b1 || {hh, mm, ss, cc} !== 32'h0) $display("FAIL set_bad_mm got err=%b %h want err=1 00000000", set_err, {hh, mm, ss, cc}); else pass_cnt++;
    wait_neg(1);
    total_cnt++; if (set_err !== 1'b0) $display("FAIL set_err_width got %b want 0", set_err); else pass_cnt++;
    do_set(8'h12, 8'h00, 8'h0A);
    total_cnt++; if (set_err !== 1'b1 || {hh, mm, ss, cc} !== 32'h0) $display("FAIL set_bad_ss got err=%b %h want err=1 00000000", set_err, {hh, mm, ss, cc}); else pass_cnt++;
    do_set(8'h24, 8'h00, 8'h00);
    total_cnt++; if (set_err !== 1'b1) $display("FAIL set_bad_hh got err=%b want 1", set_err); else pass_cnt++;
    do_set(8'h12, 8'h34, 8'h56);
    total_cnt++; if (set_err !== 1'b0 || {hh, mm, ss, cc} !== 32'h12345600) $display("FAIL set_good got err=%b %h want err=0 12345600", set_err, {hh, mm, ss, cc}); else pass_cnt++;
    wait_neg(2);
  endtask

  task automatic test_run_gate();
    int t0;
    t0 = tick_seen;
    run = 1'b0;
    pulses(20);
    total_cnt++; if ({hh, mm, ss, cc} !== 32'h12345600) $display("FAIL gate_hold got %h want 12345600", {hh, mm, ss, cc}); else pass_cnt++;
    run = 1'b1;
    pulses(5);
    total_cnt++; if (tick_seen - t0 !== 25) $display("FAIL gate_ticks got %0d want 25", tick_seen - t0); else pass_cnt++;
    total_cnt++; if ({hh, mm, ss, cc} !== 32'h12345605) $display("FAIL gate_time got %h want 12345605", {hh, mm, ss, cc}); else pass_cnt++;
  endtask

  task automatic test_coincident();
    rise();
    wait_neg(LAT);
    clear = 1'b1;
    wait_neg(1);
    clear = 1'b0;
    total_cnt++; if ({hh, mm, ss, cc} !== 32'h0) $display("FAIL clear_with_tick got %h want 00000000", {hh, mm, ss, cc}); else pass_cnt++;
    wait_neg(10 - LAT - 1);
    fall();
    wait_neg(10);
    pulses(3);
    rise();
    wait_neg(LAT);
    do_set(8'h01, 8'h02, 8'h03);
    total_cnt++; if ({hh, mm, ss, cc} !== 32'h01020300) $display("FAIL set_with_tick got %h want 01020300", {hh, mm, ss, cc}); else pass_cnt++;
    wait_neg(10 - LAT - 1);
    fall();
    wait_neg(10);
    rise();
    wait_neg(LAT);
    do_set(8'h01, 8'h7A, 8'h03);
    total_cnt++; if (set_err !== 1'b1 || {hh, mm, ss, cc} !== 32'h01020301) $display("FAIL bad_set_with_tick got err=%b %h want err=1 01020301", set_err, {hh, mm, ss, cc}); else pass_cnt++;
    wait_neg(10 - LAT - 1);
    fall();
    wait_neg(10);
  endtask

  task automatic test_random();
    int hold, rises, t0, b0, e0, me0;
    hold  = 0;
    rises = 0;
    t0    = tick_seen;
    b0    = mon_bad;
    e0    = err_seen;
    me0   = m_err_cnt;
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin
        if (div_clk) begin
          fall();
        end else begin
          rise();
          rises++;
        end
        hold = int'($urandom_range(2, 5));
      end
      hold--;
      run    = ($urandom_range(0, 3) != 0);
      clear  = ($urandom_range(0, 39) == 0);
      set_en = ($urandom_range(0, 14) == 0);
      set_hh = 8'($urandom_range(0, 8'h2F));
      set_mm = 8'($urandom_range(0, 8'h6F));
      set_ss = 8'($urandom_range(0, 8'h6F));
      wait_neg(1);
    end
    clear  = 1'b0;
    set_en = 1'b0;
    run    = 1'b1;
    fall();
    wait_neg(10);
    total_cnt++; if (tick_seen - t0 !== rises) $display("FAIL random_ticks got %0d want %0d", tick_seen - t0, rises); else pass_cnt++;
    total_cnt++; if (err_seen - e0 !== m_err_cnt - me0) $display("FAIL random_set_err got %0d want %0d", err_seen - e0, m_err_cnt - me0); else pass_cnt++;
    total_cnt++; if (mon_bad - b0 !== 0) $display("FAIL random_cycle_compare got %0d bad cycles want 0", mon_bad - b0); else pass_cnt++;
  endtask

  task automatic test_stall();
    int lt, sc;
    bit found;
    lt    = last_tick_cyc;
    found = 1'b0;
    sc    = 0;
    for (int i = 0; i < TO + 200 && !found; i++) begin
      if (stalled === 1'b1) begin
        found = 1'b1;
        sc    = cyc;
      end else begin
        wait_neg(1);
      end
    end
    total_cnt++; if (!found) $display("FAIL stall_timeout got stalled=%b want 1 within %0d cycles", stalled, TO + 200); else pass_cnt++;
    total_cnt++; if (sc - (lt + 1) !== TO) $display("FAIL stall_delay got %0d want %0d", sc - (lt + 1), TO); else pass_cnt++;
    rise();
    wait_neg(LAT);
    total_cnt++; if ({tick, stalled} !== 2'b11) $display("FAIL stall_hold got tick=%b st=%b want 1 1", tick, stalled); else pass_cnt++;
    wait_neg(1);
    total_cnt++; if (stalled !== 1'b0) $display("FAIL stall_release got %b want 0", stalled); else pass_cnt++;
    wait_neg(10 - LAT - 1);
    fall();
    wait_neg(10);
  endtask

  task automatic test_reset_mid();
    int t0;
    run = 1'b1;
    do_set(8'h00, 8'h00, 8'h07);
    wait_neg(1);
    pulses(42);
    total_cnt++; if ({hh, mm, ss, cc} !== 32'h00000742) $display("FAIL mid_pre got %h want 00000742", {hh, mm, ss, cc}); else pass_cnt++;
    rise();
    wait_neg(1);
    rst = 1'b1;
    wait_neg(1);
    total_cnt++; if ({tick, hh, mm, ss, cc, sec_pulse, day_wrap, set_err, stalled} !== 37'h0) $display("FAIL mid_reset got tick=%b %h flags=%b want all 0", tick, {hh, mm, ss, cc}, {sec_pulse, day_wrap, set_err, stalled}); else pass_cnt++;
    wait_neg(2);
    rst = 1'b0;
    tick_q.push_back(cyc + LAT);
    t0 = tick_seen;
    wait_neg(LAT);
    total_cnt++; if (tick !== 1'b1) $display("FAIL mid_release_tick got %b want 1", tick); else pass_cnt++;
    wait_neg(1);
    total_cnt++; if ({hh, mm, ss, cc} !== 32'h00000001) $display("FAIL mid_first got %h want 00000001", {hh, mm, ss, cc}); else pass_cnt++;
    wait_neg(6);
    fall();
    wait_neg(10);
    pulses(3);
    total_cnt++; if ({hh, mm, ss, cc} !== 32'h00000004 || tick_seen - t0 !== 4) $display("FAIL mid_resume got %h ticks %0d want 00000004 ticks 4", {hh, mm, ss, cc}, tick_seen - t0); else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_count();
    test_day_wrap();
    test_set_err();
    test_run_gate();
    test_coincident();
    test_random();
    test_stall();
    test_reset_mid();
    total_cnt++; if (mon_bad !== 0) $display("FAIL cycle_compare got %0d bad cycles want 0", mon_bad); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard stop in case a scenario never returns.
  initial begin
    #2000000;
    $display("FAIL global_timeout got time %0t want finish before it", $time);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1);
  end

endmodule
